// File: rtl/risc_v_cpu_pkg.sv
// Shared RV32I encodings and decode helpers for the single-cycle core.
package riscv_defs;

  // Major opcodes that do real work; anything else retires as a NOP
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct7 selecting SUB / SRA / SRAI
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] f3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] f7;
  } inst_t;

  function automatic inst_t split(input logic [31:0] i);
    inst_t d;
    d.opcode = i[6:0];
    d.rd     = i[11:7];
    d.f3     = i[14:12];
    d.rs1    = i[19:15];
    d.rs2    = i[24:20];
    d.f7     = i[31:25];
    return d;
  endfunction

  // SUB only exists for register-register ops; ADDI ignores the alt bit
  function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt,
                                      input logic reg_op);
    case (f3)
      F3_ADD:  return (reg_op && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/risc_v_cpu_if.sv
// Instruction fetch bus between the core and the program ROM.
interface risc_v_cpu_if;
  logic [29:0] addr;   // word address (PC[31:2])
  logic [31:0] instr;

  modport master (output addr, input instr);
  modport slave  (input addr, output instr);
endinterface

// File: rtl/risc_v_cpu_alu.sv
// RV32I integer ALU, purely combinational, wraps modulo 2^32.
module risc_v_alu
  import riscv_defs::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [4:0] sh;
  assign sh = b[4:0];

  // Operation select
  always_comb begin
    y = a + b;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << sh;
      ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'd0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> sh;
      ALU_SRA:  y = 32'($signed(a) >>> sh);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
  end

endmodule

// File: rtl/risc_v_cpu_core.sv
// Single-cycle RV32I core: decode, execute, writeback and next-PC each edge.
module risc_v_core
  import riscv_defs::*;
(
  input  logic          clk,
  input  logic          rst_n,
  risc_v_cpu_if.master  fetch
);
  logic [31:0] pc, pc_next, pc_plus4, instr;
  logic [31:0] imm_i, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, alu_b, alu_y, wr_data;
  logic        wr_en, br_take, alt;
  alu_op_e     alu_op;
  inst_t       d;

  assign fetch.addr = pc[31:2];
  assign instr      = fetch.instr;
  assign d          = split(instr);
  assign alt        = (d.f7 == F7_ALT);
  assign pc_plus4   = pc + 32'd4;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  risc_v_regs regs1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (d.rs1),
    .rs2_addr (d.rs2),
    .rs1_data (rs1_val),
    .rs2_data (rs2_val),
    .we       (wr_en),
    .wa       (d.rd),
    .wd       (wr_data)
  );

  risc_v_alu alu1 (
    .op (alu_op),
    .a  (rs1_val),
    .b  (alu_b),
    .y  (alu_y)
  );

  // Branch condition; reserved funct3 values never branch
  always_comb begin
    case (d.f3)
      F3_BEQ:  br_take = (rs1_val == rs2_val);
      F3_BNE:  br_take = (rs1_val != rs2_val);
      F3_BLT:  br_take = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  br_take = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_take = (rs1_val <  rs2_val);
      F3_BGEU: br_take = (rs1_val >= rs2_val);
      default: br_take = 1'b0;
    endcase
  end

  // Decode: ALU operands, writeback and next PC; unknown opcodes fall through as NOP
  always_comb begin
    alu_op  = ALU_ADD;
    alu_b   = rs2_val;
    wr_en   = 1'b0;
    wr_data = alu_y;
    pc_next = pc_plus4;
    case (d.opcode)
      OPC_OP_IMM: begin
        alu_op = alu_sel(d.f3, alt, 1'b0);
        alu_b  = imm_i;
        wr_en  = 1'b1;
      end
      OPC_OP: begin
        alu_op = alu_sel(d.f3, alt, 1'b1);
        wr_en  = 1'b1;
      end
      OPC_LUI: begin
        wr_en   = 1'b1;
        wr_data = imm_u;
      end
      OPC_AUIPC: begin
        wr_en   = 1'b1;
        wr_data = pc + imm_u;
      end
      OPC_JAL: begin
        wr_en   = 1'b1;
        wr_data = pc_plus4;
        pc_next = pc + imm_j;
      end
      OPC_JALR: begin
        // target uses rs1 as read this cycle, so rd == rs1 is safe
        wr_en   = 1'b1;
        wr_data = pc_plus4;
        pc_next = (rs1_val + imm_i) & ~32'd1;
      end
      OPC_BRANCH: begin
        if (br_take) pc_next = pc + imm_b;
      end
      default: ;
    endcase
  end

  // Program counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else        pc <= pc_next;
  end

endmodule

// File: rtl/risc_v_cpu_regs.sv
// 32x32 register file: two async read ports, one clocked write port, x0 hardwired.
module risc_v_regs (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  reg [31:0] regs [0:31];

  // Clear everything on reset; x0 is never written afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];

endmodule

// File: rtl/risc_v_cpu_rom.sv
// Program ROM: preloaded externally, read combinationally.
module risc_v_rom #(
  parameter int ROM_DEPTH = 4096
) (
  risc_v_cpu_if.slave bus
);
  localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

  reg [31:0] rom_mem [0:ROM_DEPTH-1];

  // Word index wraps at ROM_DEPTH so any PC fetches something defined
  assign bus.instr = rom_mem[AW'(bus.addr % 30'(ROM_DEPTH))];

endmodule

// File: rtl/risc_v_cpu.sv
// Top: program ROM plus single-cycle RV32I core; results live in the register file.
module risc_v_cpu #(
  parameter int ROM_DEPTH = 4096
) (
  input logic clk,
  input logic rst_n
);
  risc_v_cpu_if bus ();

  risc_v_rom #(.ROM_DEPTH(ROM_DEPTH)) rom1 (
    .bus (bus)
  );

  risc_v_core risc_v_top1 (
    .clk   (clk),
    .rst_n (rst_n),
    .fetch (bus)
  );

endmodule

// File: tb/tb_risc_v_cpu.sv
// Directed bench for risc_v_cpu: hand-assembled programs, hand-computed results.
module tb_risc_v_cpu;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] p[$];

  risc_v_cpu #(.ROM_DEPTH(4096)) dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] xr(input int i);
    return dut.risc_v_top1.regs1.regs[i];
  endfunction

  function automatic logic [31:0] pcv();
    return dut.risc_v_top1.pc;
  endfunction

  // Instruction encoders
  function automatic logic [31:0] e_i(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] e_u(input logic [19:0] imm, input logic [4:0] rd,
                                      input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] e_b(input logic [12:0] off, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
  endfunction
  function automatic logic [31:0] e_j(input logic [20:0] off, input logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6F};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return e_i(imm, rs1, 3'b000, rd, 7'h13);
  endfunction

  // Assert reset at a falling edge and load a program while the core is held
  task automatic load(input logic [31:0] prog[$]);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) dut.rom1.rom_mem[i] = 32'd0;
    foreach (prog[i]) dut.rom1.rom_mem[i] = prog[i];
    @(negedge clk);
  endtask

  // Release reset at a falling edge and let n rising edges retire n instructions
  task automatic run(input int n);
    rst_n = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // ---------------- reset state ----------------
    #1 rst_n = 1'b0;
    #30;
    chk("rst pc", pcv(), 32'h0);
    for (int i = 0; i < 32; i++) chk($sformatf("rst x%0d", i), xr(i), 32'h0);

    // ---------------- ALU sequence ----------------
    p = {
      addi(1, 0, 12'd5),                         // 00
      addi(2, 1, 12'hFF9),                       // 04 -7
      e_i(12'h000, 2, 3'b010, 3, 7'h13),         // 08 slti x3,x2,0
      e_i(12'h001, 2, 3'b011, 4, 7'h13),         // 0C sltiu x4,x2,1
      e_u(20'h80000, 5, 7'h37),                  // 10 lui x5
      e_i(12'h404, 5, 3'b101, 6, 7'h13),         // 14 srai x6,x5,4
      e_i(12'h004, 5, 3'b101, 7, 7'h13),         // 18 srli x7,x5,4
      e_r(7'h20, 1, 0, 3'b000, 8),               // 1C sub x8,x0,x1
      e_i(12'h0FF, 2, 3'b100, 9, 7'h13),         // 20 xori
      e_i(12'hFF0, 2, 3'b111, 10, 7'h13),        // 24 andi
      e_i(12'h003, 1, 3'b001, 11, 7'h13),        // 28 slli
      e_r(7'h00, 11, 1, 3'b110, 12),             // 2C or
      e_r(7'h00, 2, 1, 3'b011, 13),              // 30 sltu
      e_r(7'h00, 1, 2, 3'b010, 14),              // 34 slt
      e_r(7'h20, 1, 5, 3'b101, 15),              // 38 sra
      addi(0, 1, 12'd7)                          // 3C write to x0
    };
    load(p);
    run(1);
    chk("pc first", pcv(), 32'h4);
    step(15);
    chk("addi neg", xr(2), 32'hFFFF_FFFE);
    chk("slti", xr(3), 32'h1);
    chk("sltiu", xr(4), 32'h0);
    chk("lui", xr(5), 32'h8000_0000);
    chk("srai", xr(6), 32'hF800_0000);
    chk("srli", xr(7), 32'h0800_0000);
    chk("sub", xr(8), 32'hFFFF_FFFB);
    chk("xori", xr(9), 32'hFFFF_FF01);
    chk("andi", xr(10), 32'hFFFF_FFF0);
    chk("slli", xr(11), 32'h28);
    chk("or", xr(12), 32'h2D);
    chk("sltu", xr(13), 32'h1);
    chk("slt", xr(14), 32'h1);
    chk("sra", xr(15), 32'hFC00_0000);
    chk("x0 alu", xr(0), 32'h0);
    chk("pc alu", pcv(), 32'h40);

    // ---------------- branches ----------------
    p = {
      addi(1, 0, 12'd1),                         // 00
      addi(2, 0, 12'hFFE),                       // 04
      addi(3, 0, 12'd0),                         // 08
      addi(3, 0, 12'd0),                         // 0C
      e_b(13'd8, 0, 0, 3'b000),                  // 10 beq taken
      addi(4, 0, 12'd99),                        // 14 skipped
      e_b(13'd8, 2, 1, 3'b110),                  // 18 bltu taken
      addi(5, 0, 12'd77),                        // 1C skipped
      e_b(13'd8, 2, 1, 3'b100),                  // 20 blt not taken
      addi(6, 0, 12'd55),                        // 24
      e_b(13'd8, 1, 1, 3'b001),                  // 28 bne not taken
      e_b(13'd12, 1, 2, 3'b101),                 // 2C bge not taken
      e_b(13'd8, 1, 2, 3'b111),                  // 30 bgeu taken
      addi(7, 0, 12'd1),                         // 34 skipped
      addi(8, 0, 12'd3)                          // 38
    };
    load(p);
    run(5);
    chk("beq pc", pcv(), 32'h18);
    step(7);
    chk("beq skip", xr(4), 32'h0);
    chk("bltu skip", xr(5), 32'h0);
    chk("blt fall", xr(6), 32'd55);
    chk("bgeu skip", xr(7), 32'h0);
    chk("br tail", xr(8), 32'd3);
    chk("br pc", pcv(), 32'h3C);

    // ---------------- jumps / upper ----------------
    p = {
      addi(0, 0, 12'd5), addi(0, 0, 12'd0), addi(0, 0, 12'd0), addi(0, 0, 12'd0),
      addi(0, 0, 12'd0), addi(0, 0, 12'd0), addi(0, 0, 12'd0), addi(0, 0, 12'd0),
      e_j(21'd8, 1),                             // 20 jal x1,+8
      e_j(21'd12, 0),                            // 24 jal x0,+12
      e_i(12'h001, 1, 3'b000, 0, 7'h67),         // 28 jalr x0,1(x1)
      addi(14, 0, 12'd9),                        // 2C
      e_u(20'h00001, 9, 7'h17),                  // 30 auipc x9,1
      addi(12, 0, 12'h040),                      // 34
      e_i(12'h004, 12, 3'b000, 12, 7'h67),       // 38 jalr x12,4(x12)
      addi(14, 0, 12'd9),                        // 3C skipped
      addi(14, 0, 12'd9),                        // 40 skipped
      addi(13, 0, 12'd1)                         // 44
    };
    load(p);
    run(8);
    chk("x0 nop", xr(0), 32'h0);
    step(1);
    chk("jal rd", xr(1), 32'h24);
    chk("jal pc", pcv(), 32'h28);
    step(1);
    chk("jalr pc", pcv(), 32'h24);
    chk("jalr x0", xr(0), 32'h0);
    step(2);
    chk("auipc", xr(9), 32'h1030);

    // reset mid-program: immediate clear, ROM untouched
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid rst pc", pcv(), 32'h0);
    chk("mid rst x1", xr(1), 32'h0);
    chk("mid rst x9", xr(9), 32'h0);
    chk("rom kept", dut.rom1.rom_mem[8], 32'h0080_00EF);
    @(negedge clk);
    run(14);
    chk("jalr rd=rs1", xr(12), 32'h3C);
    chk("jalr skip", xr(14), 32'h0);
    step(1);
    chk("jalr tgt", xr(13), 32'h1);
    chk("jalr end pc", pcv(), 32'h48);

    // ---------------- self-test convention ----------------
    p = {
      addi(5, 0, 12'd3),                         // 00
      addi(6, 0, 12'd4),                         // 04
      e_r(7'h00, 6, 5, 3'b000, 7),               // 08 add
      addi(28, 0, 12'd7),                        // 0C
      e_b(13'd12, 28, 7, 3'b001),                // 10 bne -> fail
      addi(27, 0, 12'd1),                        // 14 pass
      e_j(21'd8, 0),                             // 18 jal x0,+8
      addi(27, 0, 12'd0),                        // 1C fail path
      addi(26, 0, 12'd1),                        // 20 done
      e_j(21'd0, 0)                              // 24 spin
    };
    load(p);
    run(30);
    chk("x26 done", xr(26), 32'h1);
    chk("x27 pass", xr(27), 32'h1);
    step(10);
    chk("x26 stable", xr(26), 32'h1);
    chk("x27 stable", xr(27), 32'h1);
    chk("spin pc", pcv(), 32'h24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/risc_v_cpu.md
RISC_V_CPU -- requirements
Module: risc_v_cpu

Interface
REQ-001 Parameter ROM_DEPTH, default 4096; instruction ROM depth in 32-bit words.
REQ-002 Port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 No other ports; the program is preloaded into the ROM array and results live in the register file.

Function
REQ-005 The CPU SHALL be single-cycle RV32I: one instruction fetched, decoded, executed and retired per clk rising edge.
REQ-006 PC SHALL be 32 bits, reset to 0x00000000, and update to PC+4 unless a taken branch or jump selects the target.
REQ-007 Fetch SHALL be combinational: instruction = rom_mem[PC[31:2]], with word index taken modulo ROM_DEPTH.
REQ-008 Register file SHALL hold 32 x 32-bit registers with two combinational read ports and one write port written at the clk edge.
REQ-009 Writes to x0 SHALL be discarded; x0 SHALL always read 0.
REQ-010 OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI SHALL be supported, with the 12-bit immediate sign-extended.
REQ-011 OP-IMM: SLTIU SHALL compare against the sign-extended immediate as unsigned.
REQ-012 OP: ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA SHALL be supported.
REQ-013 Shift amount = low 5 bits of rs2 or imm; SRA/SRAI replicate bit 31.
REQ-014 SLT/SLTI results SHALL be 32'd1 or 32'd0.
REQ-015 LUI SHALL write {imm[31:12],12'b0}; AUIPC SHALL write PC + {imm[31:12],12'b0}.
REQ-016 JAL SHALL write PC+4 to rd and jump to PC + sign-extended 21-bit offset.
REQ-017 JALR SHALL compute (rs1 + sext imm) & ~1 from the pre-write rs1 value, then write PC+4 to rd; rd==rs1 is legal.
REQ-018 BEQ, BNE, BLT, BGE, BLTU, BGEU SHALL branch to PC + sign-extended 13-bit offset when taken; BLT/BGE signed, BLTU/BGEU unsigned.
REQ-019 Loads, stores, FENCE, SYSTEM (ECALL/EBREAK/CSR) and undefined opcodes SHALL execute as NOP: PC+4, no register write.
REQ-020 All arithmetic SHALL be modulo 2^32; overflow is ignored.
REQ-021 Misaligned jump or branch targets SHALL NOT trap; fetch uses PC[31:2].
REQ-022 Test-completion convention: software sets x26=1 at end of test and x27=1 on pass; the hardware needs no special logic for this.

Reset
REQ-023 While rst_n=0: PC=0, all 32 registers=0, no writes occur.
REQ-024 Reset assertion mid-program SHALL immediately abort execution and clear state; rom_mem contents are not affected by reset.
REQ-025 On the first rising clk edge after rst_n deasserts, the instruction at address 0 retires.

Structure
REQ-026 Top risc_v_cpu SHALL instantiate ROM as rom1, with reg [31:0] rom_mem[0:ROM_DEPTH-1] loadable by $readmemh.
REQ-027 Top risc_v_cpu SHALL instantiate the core as risc_v_top1.
REQ-028 Core risc_v_top1 SHALL contain sub-module regs1 holding reg [31:0] regs[0:31]; these hierarchical names are fixed for benches.
REQ-029 Opcode, funct3 and funct7 constants SHALL live in a shared package or include file, riscv_defs.
REQ-030 Decoder, ALU and PC/branch logic MAY be separate modules inside risc_v_top1.

Verification
REQ-031 Reset: hold rst_n=0 for 30 ns with a 20 ns clk period -> PC=0 and every regs[i]=0; after release, PC=4 after the first edge.
REQ-032 ALU sequence:
- addi x1,x0,5; addi x2,x1,-7 -> x2=0xFFFFFFFE
- slti x3,x2,0 -> x3=1; sltiu x4,x2,1 -> x4=0
- lui x5,0x80000; srai x6,x5,4 -> x6=0xF8000000; srli x7,x5,4 -> x7=0x08000000
- sub x8,x0,x1 -> x8=0xFFFFFFFB
REQ-033 Branches:
- beq x0,x0,+8 at 0x10 -> next PC 0x18, skipped instruction writes nothing
- bltu x1(=1),x2(=0xFFFFFFFE) taken; blt with the same operands not taken
REQ-034 Jumps/upper: jal x1,+8 at 0x20 -> x1=0x24, PC=0x28; jalr x0,0x1(x1) -> PC=0x24; auipc x9,1 at 0x30 -> x9=0x1030; writes to x0 leave it 0.
REQ-035 Compliance: load each rv32ui-p image (addi..sra, beq..bgeu, lui, auipc, jal, jalr) -> x26==1 and x27==1 within the test, stable 200 ns later.
